conv_mult_stage: RTL and testbench
==================================

# conv_mult_stage

Pipelined 3x3 multiply stage of the convolver datapath. It holds a 9-tap kernel loaded serially, multiplies each incoming 3x3 pixel window tap-by-tap against it in signed fixed point, and presents 9 products. It sits directly upstream of `adder_tree`: `prod_out_0..8` feed `data_in_0..8`. Bias is added downstream and is not handled here.

## Interface
- `DATA_WIDTH`, 32: width of pixels, weights and products (signed, two's complement).
- `FRAC_BITS`, 16: fractional bits of the fixed-point format, shared by all operands.

- `clk`  in  1: sole clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `kernel_load_valid`  in  1: weight word present.
- `kernel_load_data`  in  DATA_WIDTH: weight word, tap 0 first through tap 8.
- `kernel_load_ready`  out  1: stage accepts a weight word.
- `kernel_loaded`  out  1: a complete 9-tap kernel is held.
- `window_valid`  in  1: pixel window present.
- `window_in_0..8`  in  DATA_WIDTH each: window taps, same order as the weights.
- `window_ready`  out  1: stage accepts a window.
- `prod_valid`  out  1: products valid.
- `prod_ready`  in  1: downstream accepts products.
- `prod_out_0..8`  out  DATA_WIDTH each: `window_in_k * weight_k`, scaled.

## Operation
- Handshakes: a transfer occurs on a cycle with valid && ready. Once valid is asserted, the source must hold it and the data stable until the transfer occurs.
- The kernel FSM has three states: EMPTY, LOADING and ARMED.
  - EMPTY: `kernel_load_ready` is 1. A weight transfer writes tap 0, sets tap_count = 1 and moves to LOADING.
  - LOADING: `kernel_load_ready` is 1. Each transfer writes tap[tap_count] and increments tap_count. The transfer that writes tap 8 moves to ARMED and sets `kernel_loaded`.
  - ARMED: windows are accepted. `kernel_load_ready` is 1 only when both pipeline stages are empty. A weight transfer in ARMED starts a reload: it clears `kernel_loaded`, writes tap 0 and moves to LOADING.
- Arithmetic, per tap:
  - Form the full 2*DATA_WIDTH signed product.
  - Arithmetic-shift it right by FRAC_BITS, which rounds toward negative infinity.
  - Keep the low DATA_WIDTH bits, wrapping on overflow (default build).
- All 9 taps share one valid bit per pipeline stage.

## Timing
- There are two pipeline stages:
  - S1 registers the full-width products.
  - S2 registers the shifted and narrowed results, which drive `prod_out_*`.
- Define the global enable as en = !s2_valid || prod_ready.
- `window_ready` = (state == ARMED) && en. The combinational path from `prod_ready` to `window_ready` is permitted.
- When en is 1:
  - S1 captures a window if one is transferred; otherwise S1 becomes a bubble.
  - S2 captures S1.
- When en is 0, both stages hold.
- Latency: a window transferred in cycle N appears with `prod_valid` = 1 in cycle N+2. Throughput is one window per cycle while `prod_ready` stays 1.
- Bubbles are not collapsed. While S2 stalls, S1 holds even if it is empty.
- Reset values:
  - State EMPTY, tap_count 0, all weights 0.
  - `kernel_loaded` 0, `kernel_load_ready` 1, `window_ready` 0.
  - `prod_valid` 0, all `prod_out_*` 0, both stage valid bits 0.
- Reset mid-load discards the partial kernel; a full 9-word reload is required afterwards.
- Reset with products in flight drops them; no partial output is ever presented.
- A window and a weight can never both be accepted in one cycle. Windows need the pipeline empty to be blocked only during a reload; weights in ARMED require the pipeline to be empty. If both arrive with an empty pipeline in ARMED, the window is accepted and the weight waits.
- `prod_out_*` hold their last value while `prod_valid` is 0.

## Configuration
- `CONV_MULT_SATURATE_EN`
  - Defined: after the shift, a result above 2^(DATA_WIDTH-1)-1 clamps to that maximum, and a result below -2^(DATA_WIDTH-1) clamps to that minimum. Clamping is evaluated in S2 and does not change latency.
  - Undefined: results wrap as described under Operation.

## Structure
- Package `conv_pkg` holds:
  - Default `DATA_WIDTH` and `FRAC_BITS`.
  - `KERNEL_TAPS` = 9.
  - The kernel FSM state encoding (EMPTY, LOADING, ARMED).
  - The tap-counter width, 4 bits.
- Sub-module `fx_mul`: one tap's signed multiply, S1 register, shift, optional saturate and S2 data register. It takes en as an input and is instantiated 9 times.
- The FSM, weight registers and valid bits live in the top module.

## Test plan
All scenarios use the default parameters.
- Kernel load: 9 weights with `kernel_load_valid` held at 1 → `kernel_loaded` rises on the cycle after the 9th transfer, and `window_ready` rises with it when `prod_ready` = 1.
- Identity and sign:
  - Weight 0x00010000 × pixel 0x00030000 → 0x00030000 two cycles after the window transfer.
  - Weight 0x00008000 × pixel 0xFFFF0000 → 0xFFFF8000.
- Floor rounding: weight 0x00000001 × pixel 0xFFFFFFFF → 0xFFFFFFFF. Weight 0x00000001 × pixel 0x00000001 → 0x00000000.
- Overflow: weight 0x00020000 × pixel 0x7FFF0000 → 0xFFFE0000 without `CONV_MULT_SATURATE_EN`, and 0x7FFFFFFF with it.
- Backpressure: 4 back-to-back windows with `prod_ready` dropped to 0 for 3 cycles after the first product → no product is lost or duplicated, the order is preserved, and `window_ready` is 0 throughout the stall.
- Reset mid-load and reload gating:
  - Assert `reset` after 5 weights → `kernel_loaded` stays 0 and `window_ready` stays 0 until 9 new weights are loaded.
  - In ARMED with products in flight → `kernel_load_ready` is 0 until both stages drain.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolver multiply stage: default datapath
// widths, kernel size, tap-counter width and kernel FSM state encoding.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 16;
  localparam int KERNEL_TAPS    = 9;
  localparam int TAP_CNT_W      = 4;

  // Index of the final kernel tap; writing it completes a load.
  localparam logic [TAP_CNT_W-1:0] LAST_TAP = TAP_CNT_W'(KERNEL_TAPS - 1);

  // Kernel FSM states.
  typedef enum logic [1:0] {
    KS_EMPTY   = 2'd0,
    KS_LOADING = 2'd1,
    KS_ARMED   = 2'd2
  } kstate_t;

endpackage

// File: rtl/fx_mul.sv
// One tap of the multiply stage: signed full-width multiply registered in S1,
// then arithmetic shift by FRAC_BITS (floor rounding), narrowing and an
// optional clamp registered in S2. Saturation is built only when
// CONV_MULT_SATURATE_EN is defined; otherwise the narrowed result wraps.
module fx_mul #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  s1_load,
  input  logic                  s1_full,
  input  logic [DATA_WIDTH-1:0] pixel,
  input  logic [DATA_WIDTH-1:0] weight,
  output logic [DATA_WIDTH-1:0] result
);

  logic signed [2*DATA_WIDTH-1:0] pix_ext;
  logic signed [2*DATA_WIDTH-1:0] wgt_ext;
  logic signed [2*DATA_WIDTH-1:0] prod_d;
  logic signed [2*DATA_WIDTH-1:0] prod_q;
  logic signed [2*DATA_WIDTH-1:0] shifted;
  logic        [DATA_WIDTH-1:0]   narrowed;

  // Sign-extend both operands so the product is the exact 2*W-bit value.
  assign pix_ext = $signed({{DATA_WIDTH{pixel[DATA_WIDTH-1]}}, pixel});
  assign wgt_ext = $signed({{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight});
  assign prod_d  = pix_ext * wgt_ext;

  // S1: capture the full product only when a window is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else if (en && s1_load) begin
      prod_q <= prod_d;
    end
  end

  // Arithmetic shift rounds toward negative infinity.
  assign shifted = prod_q >>> FRAC_BITS;

`ifdef CONV_MULT_SATURATE_EN
  localparam logic signed [2*DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [2*DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp out-of-range results to the representable extremes.
  always_comb begin
    narrowed = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      narrowed = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      narrowed = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  // Wrapping build: upper bits are simply discarded.
  logic unused_high;
  assign narrowed    = shifted[DATA_WIDTH-1:0];
  assign unused_high = ^shifted[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

  // S2: update only when a valid S1 entry advances, so the output holds
  // its last product across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (en && s1_full) begin
      result <= narrowed;
    end
  end

endmodule

// File: rtl/conv_mult_stage.sv
// Pipelined 3x3 multiply stage: serially loaded 9-tap kernel, two-stage
// tap-by-tap signed fixed-point multiply of each pixel window, 9 products
// out. Optional clamping of results is enabled by CONV_MULT_SATURATE_EN.
//
// Handshakes (kernel load, window, products): a transfer happens on a
// rising edge where valid && ready; once valid is raised the source holds
// valid and data stable until that transfer. kernel_state exposes the
// kernel FSM for observation.
module conv_mult_stage
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  kernel_load_valid,
  input  logic [DATA_WIDTH-1:0] kernel_load_data,
  output logic                  kernel_load_ready,
  output logic                  kernel_loaded,
  input  logic                  window_valid,
  input  logic [DATA_WIDTH-1:0] window_in_0,
  input  logic [DATA_WIDTH-1:0] window_in_1,
  input  logic [DATA_WIDTH-1:0] window_in_2,
  input  logic [DATA_WIDTH-1:0] window_in_3,
  input  logic [DATA_WIDTH-1:0] window_in_4,
  input  logic [DATA_WIDTH-1:0] window_in_5,
  input  logic [DATA_WIDTH-1:0] window_in_6,
  input  logic [DATA_WIDTH-1:0] window_in_7,
  input  logic [DATA_WIDTH-1:0] window_in_8,
  output logic                  window_ready,
  output logic                  prod_valid,
  input  logic                  prod_ready,
  output logic [DATA_WIDTH-1:0] prod_out_0,
  output logic [DATA_WIDTH-1:0] prod_out_1,
  output logic [DATA_WIDTH-1:0] prod_out_2,
  output logic [DATA_WIDTH-1:0] prod_out_3,
  output logic [DATA_WIDTH-1:0] prod_out_4,
  output logic [DATA_WIDTH-1:0] prod_out_5,
  output logic [DATA_WIDTH-1:0] prod_out_6,
  output logic [DATA_WIDTH-1:0] prod_out_7,
  output logic [DATA_WIDTH-1:0] prod_out_8,
  output kstate_t               kernel_state
);

  kstate_t                state_q;
  kstate_t                state_d;
  logic [TAP_CNT_W-1:0]   tap_count_q;
  logic [TAP_CNT_W-1:0]   tap_count_d;
  logic                   weight_we;
  logic [TAP_CNT_W-1:0]   weight_idx;
  logic [DATA_WIDTH-1:0]  weight_q [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0]  window   [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0]  prod     [KERNEL_TAPS];
  logic                   s1_valid;
  logic                   s2_valid;
  logic                   en;
  logic                   pipe_empty;
  logic                   window_fire;
  logic                   weight_fire;

  assign window[0] = window_in_0;
  assign window[1] = window_in_1;
  assign window[2] = window_in_2;
  assign window[3] = window_in_3;
  assign window[4] = window_in_4;
  assign window[5] = window_in_5;
  assign window[6] = window_in_6;
  assign window[7] = window_in_7;
  assign window[8] = window_in_8;

  assign prod_out_0 = prod[0];
  assign prod_out_1 = prod[1];
  assign prod_out_2 = prod[2];
  assign prod_out_3 = prod[3];
  assign prod_out_4 = prod[4];
  assign prod_out_5 = prod[5];
  assign prod_out_6 = prod[6];
  assign prod_out_7 = prod[7];
  assign prod_out_8 = prod[8];

  // Whole pipeline advances together unless S2 holds an unaccepted product.
  assign en         = !s2_valid || prod_ready;
  assign pipe_empty = !s1_valid && !s2_valid;

  // Windows only against a complete kernel. A reload in ARMED waits for an
  // empty pipeline and yields to a simultaneously offered window, so a
  // window and a weight are never accepted on the same edge.
  assign window_ready      = (state_q == KS_ARMED) && en;
  assign kernel_load_ready = (state_q != KS_ARMED) || (pipe_empty && !window_valid);

  assign window_fire   = window_valid && window_ready;
  assign weight_fire   = kernel_load_valid && kernel_load_ready;
  assign kernel_loaded = (state_q == KS_ARMED);
  assign prod_valid    = s2_valid;
  assign kernel_state  = state_q;

  // Kernel FSM state and tap counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= KS_EMPTY;
      tap_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tap_count_q <= tap_count_d;
    end
  end

  // Kernel FSM next state and weight write selection.
  always_comb begin
    state_d     = state_q;
    tap_count_d = tap_count_q;
    weight_we   = 1'b0;
    weight_idx  = '0;
    case (state_q)
      KS_EMPTY, KS_ARMED: begin
        if (weight_fire) begin
          weight_we   = 1'b1;
          weight_idx  = '0;
          tap_count_d = TAP_CNT_W'(1);
          state_d     = KS_LOADING;
        end
      end
      KS_LOADING: begin
        if (weight_fire) begin
          weight_we  = 1'b1;
          weight_idx = tap_count_q;
          if (tap_count_q == LAST_TAP) begin
            tap_count_d = '0;
            state_d     = KS_ARMED;
          end else begin
            tap_count_d = tap_count_q + TAP_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = KS_EMPTY;
        tap_count_d = '0;
      end
    endcase
  end

  // Weight register file, cleared by reset so a partial kernel is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        weight_q[k] <= '0;
      end
    end else if (weight_we) begin
      weight_q[weight_idx] <= kernel_load_data;
    end
  end

  // Shared stage valid bits; bubbles are kept, both stages hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= window_fire;
      s2_valid <= s1_valid;
    end
  end

  for (genvar k = 0; k < KERNEL_TAPS; k++) begin : g_tap
    fx_mul #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .s1_load (window_fire),
      .s1_full (s1_valid),
      .pixel   (window[k]),
      .weight  (weight_q[k]),
      .result  (prod[k])
    );
  end

endmodule

// File: tb/tb_conv_mult_stage.sv
// Directed bench for conv_mult_stage: kernel load, fixed-point arithmetic
// vectors, backpressure ordering, reload gating and reset behaviour.
module tb_conv_mult_stage;
  import conv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          kernel_load_valid;
  logic [W-1:0]  kernel_load_data;
  logic          kernel_load_ready;
  logic          kernel_loaded;
  logic          window_valid;
  logic [W-1:0]  pix [9];
  logic          window_ready;
  logic          prod_valid;
  logic          prod_ready;
  logic [W-1:0]  prod [9];
  kstate_t       kernel_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] kw   [9];
  logic [W-1:0] kpix [9];
  logic [W-1:0] kexp [9];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  conv_mult_stage dut (
    .clk               (clk),
    .reset             (reset),
    .kernel_load_valid (kernel_load_valid),
    .kernel_load_data  (kernel_load_data),
    .kernel_load_ready (kernel_load_ready),
    .kernel_loaded     (kernel_loaded),
    .window_valid      (window_valid),
    .window_in_0       (pix[0]),
    .window_in_1       (pix[1]),
    .window_in_2       (pix[2]),
    .window_in_3       (pix[3]),
    .window_in_4       (pix[4]),
    .window_in_5       (pix[5]),
    .window_in_6       (pix[6]),
    .window_in_7       (pix[7]),
    .window_in_8       (pix[8]),
    .window_ready      (window_ready),
    .prod_valid        (prod_valid),
    .prod_ready        (prod_ready),
    .prod_out_0        (prod[0]),
    .prod_out_1        (prod[1]),
    .prod_out_2        (prod[2]),
    .prod_out_3        (prod[3]),
    .prod_out_4        (prod[4]),
    .prod_out_5        (prod[5]),
    .prod_out_6        (prod[6]),
    .prod_out_7        (prod[7]),
    .prod_out_8        (prod[8]),
    .kernel_state      (kernel_state)
  );

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_weight(input logic [W-1:0] w);
    int t;
    t = 0;
    kernel_load_valid = 1'b1;
    kernel_load_data  = w;
    #1;
    while (!kernel_load_ready && t < 40) begin
      @(negedge clk); #1; t++;
    end
    checks++;
    if (t >= 40) begin
      errors++;
      $display("FAIL weight_accept_timeout: kernel_load_ready=%0b required 1", kernel_load_ready);
    end
    @(negedge clk);
    kernel_load_valid = 1'b0;
  endtask

  task automatic send_window();
    int t;
    t = 0;
    window_valid = 1'b1;
    #1;
    while (!window_ready && t < 40) begin
      @(negedge clk); #1; t++;
    end
    checks++;
    if (t >= 40) begin
      errors++;
      $display("FAIL window_accept_timeout: window_ready=%0b required 1", window_ready);
    end
    @(negedge clk);
    window_valid = 1'b0;
  endtask

  task automatic set_pix_zero();
    for (int k = 0; k < 9; k++) pix[k] = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    kernel_load_valid = 1'b0;
    kernel_load_data  = '0;
    window_valid = 1'b0;
    prod_ready   = 1'b1;
    set_pix_zero();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (kernel_loaded !== 1'b0) begin errors++; $display("FAIL reset_kernel_loaded: got %0b expected 0", kernel_loaded); end
    checks++;
    if (kernel_load_ready !== 1'b1) begin errors++; $display("FAIL reset_kernel_load_ready: got %0b expected 1", kernel_load_ready); end
    checks++;
    if (window_ready !== 1'b0) begin errors++; $display("FAIL reset_window_ready: got %0b expected 0", window_ready); end
    checks++;
    if (prod_valid !== 1'b0) begin errors++; $display("FAIL reset_prod_valid: got %0b expected 0", prod_valid); end
    checks++;
    if (kernel_state !== KS_EMPTY) begin errors++; $display("FAIL reset_state: got %0d expected %0d", kernel_state, KS_EMPTY); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (prod[k] !== '0) begin errors++; $display("FAIL reset_prod_out_%0d: got %h expected 0", k, prod[k]); end
    end
  endtask

  task automatic test_kernel_load();
    prod_ready = 1'b1;
    kernel_load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      kernel_load_data = kw[i];
      #1;
      checks++;
      if (kernel_load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_tap%0d: got %0b expected 1", i, kernel_load_ready); end
      checks++;
      if (kernel_loaded !== 1'b0) begin errors++; $display("FAIL load_early_loaded_tap%0d: got %0b expected 0", i, kernel_loaded); end
      @(negedge clk);
    end
    kernel_load_valid = 1'b0;
    #1;
    checks++;
    if (kernel_loaded !== 1'b1) begin errors++; $display("FAIL load_kernel_loaded: got %0b expected 1", kernel_loaded); end
    checks++;
    if (window_ready !== 1'b1) begin errors++; $display("FAIL load_window_ready: got %0b expected 1", window_ready); end
    checks++;
    if (kernel_state !== KS_ARMED) begin errors++; $display("FAIL load_state: got %0d expected %0d", kernel_state, KS_ARMED); end
    @(negedge clk);
  endtask

  task automatic test_arith();
    prod_ready = 1'b1;
    for (int k = 0; k < 9; k++) pix[k] = kpix[k];
    send_window();
    set_pix_zero();
    #1;
    checks++;
    if (prod_valid !== 1'b0) begin errors++; $display("FAIL arith_latency_early: prod_valid=%0b expected 0", prod_valid); end
    @(negedge clk); #1;
    checks++;
    if (prod_valid !== 1'b1) begin errors++; $display("FAIL arith_latency: prod_valid=%0b expected 1", prod_valid); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (prod[k] !== kexp[k]) begin errors++; $display("FAIL arith_tap%0d: got %h expected %h", k, prod[k], kexp[k]); end
    end
    @(negedge clk); #1;
    checks++;
    if (prod_valid !== 1'b0) begin errors++; $display("FAIL arith_single: prod_valid=%0b expected 0", prod_valid); end
    checks++;
    if (prod[0] !== kexp[0]) begin errors++; $display("FAIL arith_hold: got %h expected %h", prod[0], kexp[0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int stall;
    int cyc;
    bit first_done;
    logic [W-1:0] e;
    sent = 0; got = 0; stall = 0; cyc = 0; first_done = 1'b0;
    exp_q.delete();
    while (got < 4 && cyc < 60) begin
      prod_ready = (stall == 0);
      if (sent < 4) begin
        set_pix_zero();
        pix[0] = W'((sent + 1) << 16);
        pix[5] = W'((sent + 1) << 16);
        window_valid = 1'b1;
      end else begin
        window_valid = 1'b0;
      end
      #1;
      if (prod_valid && !prod_ready) begin
        checks++;
        if (window_ready !== 1'b0) begin errors++; $display("FAIL bp_window_ready_stall: got %0b expected 0", window_ready); end
      end
      if (window_valid && window_ready) begin
        exp_q.push_back(pix[0]);
        sent++;
      end
      if (prod_valid && prod_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_product: got %h expected none", prod[0]);
        end else begin
          e = exp_q.pop_front();
          if (prod[0] !== e) begin errors++; $display("FAIL bp_order_tap0: got %h expected %h", prod[0], e); end
          checks++;
          if (prod[5] !== (~e + 1'b1)) begin errors++; $display("FAIL bp_order_tap5: got %h expected %h", prod[5], ~e + 1'b1); end
        end
        got++;
        if (!first_done) begin
          first_done = 1'b1;
          stall = 3;
        end
      end else if (!prod_ready) begin
        stall--;
      end
      @(negedge clk);
      cyc++;
    end
    window_valid = 1'b0;
    prod_ready = 1'b1;
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d products (pending %0d) expected 4", got, exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (prod_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: prod_valid=%0b expected 0", prod_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reload_gating();
    prod_ready = 1'b1;
    for (int k = 0; k < 9; k++) pix[k] = kpix[k];
    window_valid = 1'b1;
    kernel_load_valid = 1'b1;
    kernel_load_data = kw[0];
    #1;
    checks++;
    if (window_ready !== 1'b1) begin errors++; $display("FAIL gate_window_wins: window_ready=%0b expected 1", window_ready); end
    checks++;
    if (kernel_load_ready !== 1'b0) begin errors++; $display("FAIL gate_weight_waits: kernel_load_ready=%0b expected 0", kernel_load_ready); end
    @(negedge clk);
    window_valid = 1'b0;
    prod_ready = 1'b0;
    #1;
    checks++;
    if (kernel_load_ready !== 1'b0) begin errors++; $display("FAIL gate_s1_busy: kernel_load_ready=%0b expected 0", kernel_load_ready); end
    @(negedge clk); #1;
    checks++;
    if (kernel_load_ready !== 1'b0) begin errors++; $display("FAIL gate_s2_busy: kernel_load_ready=%0b expected 0", kernel_load_ready); end
    @(negedge clk); #1;
    checks++;
    if (kernel_load_ready !== 1'b0 || prod_valid !== 1'b1) begin
      errors++; $display("FAIL gate_stalled: kernel_load_ready=%0b prod_valid=%0b expected 0 and 1", kernel_load_ready, prod_valid);
    end
    checks++;
    if (prod[0] !== kexp[0]) begin errors++; $display("FAIL gate_product: got %h expected %h", prod[0], kexp[0]); end
    prod_ready = 1'b1;
    #1;
    checks++;
    if (kernel_load_ready !== 1'b0) begin errors++; $display("FAIL gate_draining: kernel_load_ready=%0b expected 0", kernel_load_ready); end
    @(negedge clk); #1;
    checks++;
    if (kernel_load_ready !== 1'b1 || prod_valid !== 1'b0) begin
      errors++; $display("FAIL gate_drained: kernel_load_ready=%0b prod_valid=%0b expected 1 and 0", kernel_load_ready, prod_valid);
    end
    @(negedge clk);
    kernel_load_valid = 1'b0;
    #1;
    checks++;
    if (kernel_loaded !== 1'b0 || window_ready !== 1'b0 || kernel_state !== KS_LOADING) begin
      errors++; $display("FAIL gate_reload_start: loaded=%0b window_ready=%0b state=%0d expected 0 0 %0d",
                         kernel_loaded, window_ready, kernel_state, KS_LOADING);
    end
    for (int i = 1; i < 9; i++) send_weight(kw[i]);
    #1;
    checks++;
    if (kernel_loaded !== 1'b1) begin errors++; $display("FAIL gate_reload_done: got %0b expected 1", kernel_loaded); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    prod_ready = 1'b1;
    for (int k = 0; k < 9; k++) pix[k] = kpix[k];
    send_window();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (prod_valid !== 1'b0) begin errors++; $display("FAIL flight_dropped_%0d: prod_valid=%0b expected 0", i, prod_valid); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (prod[0] !== '0 || kernel_loaded !== 1'b0) begin
      errors++; $display("FAIL flight_cleared: prod_out_0=%h loaded=%0b expected 0 and 0", prod[0], kernel_loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    prod_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_weight(kw[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (kernel_state !== KS_EMPTY || kernel_loaded !== 1'b0) begin
      errors++; $display("FAIL midload_discard: state=%0d loaded=%0b expected %0d and 0", kernel_state, kernel_loaded, KS_EMPTY);
    end
    @(negedge clk);
    for (int k = 0; k < 9; k++) pix[k] = kpix[k];
    window_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (window_ready !== 1'b0 || kernel_loaded !== 1'b0) begin
        errors++; $display("FAIL midload_gate_%0d: window_ready=%0b loaded=%0b expected 0 and 0", i, window_ready, kernel_loaded);
      end
      send_weight(kw[i]);
    end
    #1;
    checks++;
    if (kernel_loaded !== 1'b1 || window_ready !== 1'b1) begin
      errors++; $display("FAIL midload_rearmed: loaded=%0b window_ready=%0b expected 1 and 1", kernel_loaded, window_ready);
    end
    @(negedge clk);
    window_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (prod_valid !== 1'b1) begin errors++; $display("FAIL midload_prod_valid: got %0b expected 1", prod_valid); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (prod[k] !== kexp[k]) begin errors++; $display("FAIL midload_tap%0d: got %h expected %h", k, prod[k], kexp[k]); end
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    kw   = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0001, 32'h0000_0001, 32'h0002_0000,
             32'hFFFF_0000, 32'h0001_8000, 32'h0002_0000, 32'hFFFF_FFFF};
    kpix = '{32'h0003_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_0000,
             32'h0005_0000, 32'h0002_0000, 32'h8000_0000, 32'h0001_0000};
`ifdef CONV_MULT_SATURATE_EN
    kexp = '{32'h0003_0000, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF,
             32'hFFFB_0000, 32'h0003_0000, 32'h8000_0000, 32'hFFFF_FFFF};
`else
    kexp = '{32'h0003_0000, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFE_0000,
             32'hFFFB_0000, 32'h0003_0000, 32'h0000_0000, 32'hFFFF_FFFF};
`endif
    test_reset();
    test_kernel_load();
    test_arith();
    test_back_to_back();
    test_reload_gating();
    test_reset_in_flight();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
